// File: rtl/mesa_pkg.sv
// rtl/mesa_pkg.sv - shared MesaBus constants and Ro receive FSM encoding
package mesa_pkg;

    localparam logic [7:0] MESA_PREAMBLE   = 8'hF0;
    localparam logic [7:0] MESA_SLOT_RO    = 8'hFE;
    localparam logic [7:0] MESA_SUBSLOT_ID = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLOT,
        ST_SUBSLOT,
        ST_LEN,
        ST_PAYLOAD,
        ST_DONE
    } rx_state_t;

endpackage

// File: rtl/mesa_ro_rx_if.sv
// rtl/mesa_ro_rx_if.sv - Ro byte stream bundle (byte, byte strobe, done strobe)
interface mesa_ro_rx_if;
    logic [7:0] ro_byte_d;
    logic       ro_byte_en;
    logic       ro_done;

    modport master (output ro_byte_d, output ro_byte_en, output ro_done);
    modport slave  (input  ro_byte_d, input  ro_byte_en, input  ro_done);
endinterface

// File: rtl/mesa_word_pack.sv
// rtl/mesa_word_pack.sv - packs bytes big-endian into 32-bit words
// A flush emits any partial word left-aligned and zero-padded, including a byte arriving with it.
module mesa_word_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_d,
    input  logic        flush,
    output logic [31:0] word_d,
    output logic        word_en
);

    logic [31:0] sreg, sreg_nx, padded;
    logic [1:0]  phase, phase_nx;

    always_comb begin
        sreg_nx  = byte_en ? {sreg[23:0], byte_d} : sreg;
        phase_nx = phase + {1'b0, byte_en};
        case (phase_nx)
            2'd1:    padded = {sreg_nx[7:0],  24'h0};
            2'd2:    padded = {sreg_nx[15:0], 16'h0};
            2'd3:    padded = {sreg_nx[23:0], 8'h0};
            default: padded = sreg_nx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            phase   <= '0;
            word_d  <= '0;
            word_en <= 1'b0;
        end else begin
            word_en <= 1'b0;
            if (byte_en && phase == 2'd3) begin
                word_d  <= sreg_nx;
                word_en <= 1'b1;
            end else if (flush && phase_nx != 2'd0) begin
                word_d  <= padded;
                word_en <= 1'b1;
            end
            if (clr || flush) begin
                sreg  <= '0;
                phase <= '0;
            end else begin
                sreg  <= sreg_nx;
                phase <= phase_nx;
            end
        end
    end

endmodule

// File: rtl/mesa_ro_rx.sv
// rtl/mesa_ro_rx.sv - MesaBus Ro receiver: header parse, word packing, ID report capture
module mesa_ro_rx
    import mesa_pkg::*;
#(
    parameter int         MAX_BYTES  = 64,
    parameter logic [7:0] ID_SLOT    = MESA_SLOT_RO,
    parameter logic [7:0] ID_SUBSLOT = MESA_SUBSLOT_ID
) (
    input  logic        clk,
    input  logic        reset_n,
    mesa_ro_rx_if.slave ro,
    output logic [7:0]  hdr_slot,
    output logic [7:0]  hdr_subslot,
    output logic [7:0]  hdr_len,
    output logic [31:0] word_d,
    output logic        word_en,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic        len_mismatch,
    output logic [31:0] id_mfr,
    output logic [31:0] id_dev,
    output logic [31:0] id_snum,
    output logic [31:0] id_tstamp,
    output logic        id_valid
);

    localparam logic [8:0] MAX_B = 9'(MAX_BYTES);

    rx_state_t   state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        err, err_nx;
    logic        pk_en, pk_clr, pk_flush;
    logic [2:0]  wcnt;
    logic [31:0] wbuf [4];
    logic [31:0] live [4];
    logic        capture;

    mesa_word_pack u_pack (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr     (pk_clr),
        .byte_en (pk_en),
        .byte_d  (ro.ro_byte_d),
        .flush   (pk_flush),
        .word_d  (word_d),
        .word_en (word_en)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = err;
        pk_en    = 1'b0;
        pk_clr   = 1'b0;
        pk_flush = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ro.ro_byte_en && ro.ro_byte_d == MESA_PREAMBLE) begin
                    state_nx = ST_SLOT;
                    cnt_nx   = '0;
                    err_nx   = 1'b0;
                end
            end
            ST_SLOT, ST_SUBSLOT, ST_LEN: begin
                if (ro.ro_done) begin
                    state_nx = ST_DONE;
                    err_nx   = 1'b1;
                end else if (ro.ro_byte_en) begin
                    case (state)
                        ST_SLOT:    state_nx = ST_SUBSLOT;
                        ST_SUBSLOT: state_nx = ST_LEN;
                        default: begin
                            state_nx = ST_PAYLOAD;
                            cnt_nx   = '0;
                            pk_clr   = 1'b1;
                        end
                    endcase
                end
            end
            ST_PAYLOAD: begin
                if (ro.ro_byte_en) begin
                    if (cnt != 8'hFF) cnt_nx = cnt + 8'd1;
                    // Bytes past the limit are counted but never reach the packer.
                    if ({1'b0, cnt} < MAX_B) pk_en = 1'b1;
                    else                     err_nx = 1'b1;
                end
                if (ro.ro_done) begin
                    state_nx = ST_DONE;
                    pk_flush = !err_nx;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // The 4th word can still be in flight during DONE, so take it straight off the packer.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            live[i] = (word_en && wcnt == 3'(i)) ? word_d : wbuf[i];
        end
    end

    assign capture = (state == ST_DONE) && !err && hdr_slot == ID_SLOT &&
                     hdr_subslot == ID_SUBSLOT && cnt >= 8'd16;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            err          <= 1'b0;
            wcnt         <= '0;
            for (int i = 0; i < 4; i++) wbuf[i] <= '0;
            hdr_slot     <= '0;
            hdr_subslot  <= '0;
            hdr_len      <= '0;
            pkt_done     <= 1'b0;
            pkt_err      <= 1'b0;
            len_mismatch <= 1'b0;
            id_mfr       <= '0;
            id_dev       <= '0;
            id_snum      <= '0;
            id_tstamp    <= '0;
            id_valid     <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err   <= err_nx;
            if (ro.ro_byte_en) begin
                if (state == ST_SLOT)    hdr_slot    <= ro.ro_byte_d;
                if (state == ST_SUBSLOT) hdr_subslot <= ro.ro_byte_d;
                if (state == ST_LEN)     hdr_len     <= ro.ro_byte_d;
            end
            if (pk_clr) begin
                wcnt <= '0;
            end else if (word_en && !wcnt[2]) begin
                wbuf[wcnt[1:0]] <= word_d;
                wcnt            <= wcnt + 3'd1;
            end
            pkt_done     <= (state != ST_DONE) && (state_nx == ST_DONE);
            pkt_err      <= (state != ST_DONE) && (state_nx == ST_DONE) && err_nx;
            len_mismatch <= (state == ST_PAYLOAD) && (state_nx == ST_DONE) && (cnt_nx != hdr_len);
            if (capture) begin
                id_mfr    <= live[0];
                id_dev    <= live[1];
                id_snum   <= live[2];
                id_tstamp <= live[3];
                id_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mesa_ro_rx.sv
// tb/tb_mesa_ro_rx.sv - directed self-checking bench for mesa_ro_rx
module tb_mesa_ro_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] bd = 8'h00;
    logic       be = 1'b0;
    logic       bdn = 1'b0;

    always #5 clk = ~clk;

    mesa_ro_rx_if ro_a ();
    mesa_ro_rx_if ro_b ();
    assign ro_a.ro_byte_d = bd;
    assign ro_a.ro_byte_en = be;
    assign ro_a.ro_done = bdn;
    assign ro_b.ro_byte_d = bd;
    assign ro_b.ro_byte_en = be;
    assign ro_b.ro_done = bdn;

    logic [7:0]  hdr_slot, hdr_subslot, hdr_len;
    logic [31:0] word_d, id_mfr, id_dev, id_snum, id_tstamp;
    logic        word_en, pkt_done, pkt_err, len_mismatch, id_valid;

    logic [7:0]  hdr_slot8, hdr_subslot8, hdr_len8;
    logic [31:0] word_d8, id_mfr8, id_dev8, id_snum8, id_tstamp8;
    logic        word_en8, pkt_done8, pkt_err8, len_mismatch8, id_valid8;

    mesa_ro_rx dut (
        .clk(clk), .reset_n(reset_n), .ro(ro_a.slave),
        .hdr_slot(hdr_slot), .hdr_subslot(hdr_subslot), .hdr_len(hdr_len),
        .word_d(word_d), .word_en(word_en), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .len_mismatch(len_mismatch), .id_mfr(id_mfr), .id_dev(id_dev),
        .id_snum(id_snum), .id_tstamp(id_tstamp), .id_valid(id_valid)
    );

    mesa_ro_rx #(.MAX_BYTES(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .ro(ro_b.slave),
        .hdr_slot(hdr_slot8), .hdr_subslot(hdr_subslot8), .hdr_len(hdr_len8),
        .word_d(word_d8), .word_en(word_en8), .pkt_done(pkt_done8), .pkt_err(pkt_err8),
        .len_mismatch(len_mismatch8), .id_mfr(id_mfr8), .id_dev(id_dev8),
        .id_snum(id_snum8), .id_tstamp(id_tstamp8), .id_valid(id_valid8)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] wq [$];
    int          w8_cnt = 0;
    int          done_cnt = 0;
    int          done8_cnt = 0;
    logic        last_err = 1'b0, last_lm = 1'b0, last_err8 = 1'b0;

    always @(negedge clk) begin
        if (word_en) wq.push_back(word_d);
        if (word_en8) w8_cnt++;
        if (pkt_done) begin
            done_cnt++;
            last_err = pkt_err;
            last_lm  = len_mismatch;
        end
        if (pkt_done8) begin
            done8_cnt++;
            last_err8 = pkt_err8;
        end
    end

    task automatic put(input logic [7:0] b, input logic en, input logic dn);
        bd  = b;
        be  = en;
        bdn = dn;
        @(posedge clk);
        #1;
        be  = 1'b0;
        bdn = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q [$]);
        for (int i = 0; i < q.size(); i++) put(q[i], 1'b1, i == q.size() - 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hdr_slot !== 8'h00) begin failures++; $display("FAIL reset_hdr_slot got=%h exp=00", hdr_slot); end
        checks++; if (word_en !== 1'b0 || word_d !== 32'h0) begin failures++; $display("FAIL reset_word got=%b/%h exp=0/0", word_en, word_d); end
        checks++; if (pkt_done !== 1'b0 || pkt_err !== 1'b0) begin failures++; $display("FAIL reset_pkt got=%b%b exp=00", pkt_done, pkt_err); end
        checks++; if (id_valid !== 1'b0 || id_mfr !== 32'h0) begin failures++; $display("FAIL reset_id got=%b/%h exp=0/0", id_valid, id_mfr); end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_short;
        logic [7:0] q [$] = '{8'hF0, 8'h22, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        int n0 = wq.size();
        int d0 = done_cnt;
        send_q(q);
        checks++; if (wq.size() - n0 !== 1) begin failures++; $display("FAIL short_word_count got=%0d exp=1", wq.size() - n0); end
        else begin
            checks++; if (wq[n0] !== 32'hAABBCC00) begin failures++; $display("FAIL short_flush_word got=%h exp=aabbcc00", wq[n0]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL short_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (last_err !== 1'b0 || last_lm !== 1'b0) begin failures++; $display("FAIL short_flags got=%b%b exp=00", last_err, last_lm); end
        checks++; if ({hdr_slot, hdr_subslot, hdr_len} !== 24'h220103) begin failures++; $display("FAIL short_hdr got=%h exp=220103", {hdr_slot, hdr_subslot, hdr_len}); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL short_id_valid got=%b exp=0", id_valid); end
    endtask

    task automatic test_id_report;
        logic [31:0] w [5] = '{32'h12345678, 32'h9ABCDEF0, 32'h00000001, 32'h5F000000, 32'hCAFEBABE};
        logic [7:0] q [$] = '{8'hF0, 8'hFE, 8'h00, 8'h10};
        int n0 = wq.size();
        for (int i = 0; i < 5; i++) for (int j = 3; j >= 0; j--) q.push_back(w[i][8*j +: 8]);
        send_q(q);
        checks++; if (wq.size() - n0 !== 5) begin failures++; $display("FAIL id_word_count got=%0d exp=5", wq.size() - n0); end
        else for (int i = 0; i < 5; i++) begin
            checks++; if (wq[n0+i] !== w[i]) begin failures++; $display("FAIL id_word%0d got=%h exp=%h", i, wq[n0+i], w[i]); end
        end
        checks++; if ({id_mfr, id_dev} !== {w[0], w[1]}) begin failures++; $display("FAIL id_mfr_dev got=%h %h exp=%h %h", id_mfr, id_dev, w[0], w[1]); end
        checks++; if ({id_snum, id_tstamp} !== {w[2], w[3]}) begin failures++; $display("FAIL id_snum_ts got=%h %h exp=%h %h", id_snum, id_tstamp, w[2], w[3]); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL id_valid got=%b exp=1", id_valid); end
        checks++; if (last_err !== 1'b0 || last_lm !== 1'b1) begin failures++; $display("FAIL id_flags err/lm got=%b%b exp=01", last_err, last_lm); end
    endtask

    task automatic test_noise;
        logic [7:0] q [$] = '{8'h00, 8'h55, 8'hF0, 8'hFE, 8'h00, 8'h10};
        int n0 = wq.size();
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        send_q(q);
        checks++; if (wq.size() - n0 !== 4) begin failures++; $display("FAIL noise_word_count got=%0d exp=4", wq.size() - n0); end
        checks++; if (id_mfr !== 32'h00010203) begin failures++; $display("FAIL noise_mfr got=%h exp=00010203", id_mfr); end
        checks++; if (id_tstamp !== 32'h0C0D0E0F) begin failures++; $display("FAIL noise_tstamp got=%h exp=0c0d0e0f", id_tstamp); end
        checks++; if (last_lm !== 1'b0 || last_err !== 1'b0) begin failures++; $display("FAIL noise_flags got=%b%b exp=00", last_err, last_lm); end
    endtask

    task automatic test_truncated;
        logic [7:0] q [$] = '{8'hF0, 8'hFE};
        int n0 = wq.size();
        int d0 = done_cnt;
        send_q(q);
        checks++; if (done_cnt - d0 !== 1 || last_err !== 1'b1) begin failures++; $display("FAIL trunc_done_err got=%0d/%b exp=1/1", done_cnt - d0, last_err); end
        checks++; if (wq.size() !== n0) begin failures++; $display("FAIL trunc_words got=%0d exp=0", wq.size() - n0); end
        checks++; if (id_mfr !== 32'h00010203 || id_valid !== 1'b1) begin failures++; $display("FAIL trunc_id_held got=%h/%b exp=00010203/1", id_mfr, id_valid); end
    endtask

    task automatic test_done_alone;
        int n0 = wq.size();
        put(8'hF0, 1'b1, 1'b0); put(8'h33, 1'b1, 1'b0); put(8'h00, 1'b1, 1'b0); put(8'h02, 1'b1, 1'b0);
        put(8'h11, 1'b1, 1'b0); put(8'h22, 1'b1, 1'b0); put(8'h00, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (wq.size() - n0 !== 1) begin failures++; $display("FAIL done_alone_count got=%0d exp=1", wq.size() - n0); end
        else begin
            checks++; if (wq[n0] !== 32'h11220000) begin failures++; $display("FAIL done_alone_word got=%h exp=11220000", wq[n0]); end
        end
        checks++; if (last_err !== 1'b0 || last_lm !== 1'b0) begin failures++; $display("FAIL done_alone_flags got=%b%b exp=00", last_err, last_lm); end
    endtask

    task automatic test_overflow;
        logic [7:0] q [$] = '{8'hF0, 8'hFE, 8'h00, 8'h0C};
        int w0 = w8_cnt;
        int d0 = done8_cnt;
        int n0 = wq.size();
        for (int i = 0; i < 12; i++) q.push_back(8'h40 + 8'(i));
        send_q(q);
        checks++; if (w8_cnt - w0 !== 2) begin failures++; $display("FAIL ovf_words got=%0d exp=2", w8_cnt - w0); end
        checks++; if (done8_cnt - d0 !== 1 || last_err8 !== 1'b1) begin failures++; $display("FAIL ovf_err got=%0d/%b exp=1/1", done8_cnt - d0, last_err8); end
        checks++; if (id_valid8 !== 1'b0) begin failures++; $display("FAIL ovf_no_capture got=%b exp=0", id_valid8); end
        checks++; if (wq.size() - n0 !== 3 || last_err !== 1'b0) begin failures++; $display("FAIL ovf_wide_ref got=%0d/%b exp=3/0", wq.size() - n0, last_err); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] w [4] = '{32'hA1B2C3D4, 32'h0F1E2D3C, 32'h00000007, 32'h60000001};
        logic [7:0] q [$] = '{8'hF0, 8'hFE, 8'h00, 8'h10};
        int n0;
        put(8'hF0, 1'b1, 1'b0); put(8'hFE, 1'b1, 1'b0); put(8'h00, 1'b1, 1'b0); put(8'h10, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) put(8'h90 + 8'(i), 1'b1, 1'b0);
        reset_n = 1'b0;
        #2;
        checks++; if (hdr_slot !== 8'h00 || id_valid !== 1'b0 || id_mfr !== 32'h0) begin failures++; $display("FAIL mid_reset_outputs got=%h/%b/%h exp=00/0/0", hdr_slot, id_valid, id_mfr); end
        checks++; if (word_en !== 1'b0 || word_d !== 32'h0) begin failures++; $display("FAIL mid_reset_word got=%b/%h exp=0/0", word_en, word_d); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n0 = wq.size();
        for (int i = 0; i < 4; i++) for (int j = 3; j >= 0; j--) q.push_back(w[i][8*j +: 8]);
        send_q(q);
        checks++; if (wq.size() - n0 !== 4) begin failures++; $display("FAIL mid_word_count got=%0d exp=4", wq.size() - n0); end
        else begin
            checks++; if (wq[n0] !== w[0]) begin failures++; $display("FAIL mid_first_word got=%h exp=%h", wq[n0], w[0]); end
        end
        checks++; if ({id_mfr, id_dev, id_snum, id_tstamp} !== {w[0], w[1], w[2], w[3]}) begin failures++; $display("FAIL mid_capture got=%h %h %h %h", id_mfr, id_dev, id_snum, id_tstamp); end
        checks++; if (id_valid !== 1'b1 || last_lm !== 1'b0) begin failures++; $display("FAIL mid_valid_lm got=%b/%b exp=1/0", id_valid, last_lm); end
    endtask

    initial begin
        #1;
        test_reset;
        test_short;
        test_id_report;
        test_noise;
        test_truncated;
        test_done_alone;
        test_overflow;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
